// File: rtl/axi3_rd_arbiter_if.sv
// axi3_if: full AXI3 channel bundle with master and slave views.
// Every attached port shares ACLK; the arbiter only uses the read channels.
interface axi3_if #(
    parameter int N_BYTES    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int ID_WIDTH   = 4
) (
    input logic ACLK
);
    logic [ID_WIDTH-1:0]    AWID;
    logic [ADDR_WIDTH-1:0]  AWADDR;
    logic [3:0]             AWLEN;
    logic [2:0]             AWSIZE;
    logic [1:0]             AWBURST;
    logic [1:0]             AWLOCK;
    logic [3:0]             AWCACHE;
    logic [2:0]             AWPROT;
    logic [3:0]             AWQOS;
    logic                   AWVALID;
    logic                   AWREADY;

    logic [ID_WIDTH-1:0]    WID;
    logic [8*N_BYTES-1:0]   WDATA;
    logic [N_BYTES-1:0]     WSTRB;
    logic                   WLAST;
    logic                   WVALID;
    logic                   WREADY;

    logic [ID_WIDTH-1:0]    BID;
    logic [1:0]             BRESP;
    logic                   BVALID;
    logic                   BREADY;

    logic [ID_WIDTH-1:0]    ARID;
    logic [ADDR_WIDTH-1:0]  ARADDR;
    logic [3:0]             ARLEN;
    logic [2:0]             ARSIZE;
    logic [1:0]             ARBURST;
    logic [1:0]             ARLOCK;
    logic [3:0]             ARCACHE;
    logic [2:0]             ARPROT;
    logic [3:0]             ARQOS;
    logic                   ARVALID;
    logic                   ARREADY;

    logic [ID_WIDTH-1:0]    RID;
    logic [8*N_BYTES-1:0]   RDATA;
    logic [1:0]             RRESP;
    logic                   RLAST;
    logic                   RVALID;
    logic                   RREADY;

    modport master (
        input  ACLK,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  ACLK,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi3_rd_arbiter.sv
// axi3_rd_arbiter: 2:1 round-robin AXI3 read arbiter. The granted master index
// becomes the downstream ARID MSB and steers R beats back; write channels are tied off.
module axi3_rd_arbiter #(
    parameter int N_BYTES    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_OUTST  = 8
) (
    input logic     ACLK,
    input logic     ARESETn,
    axi3_if.slave   s0,
    axi3_if.slave   s1,
    axi3_if.master  m
);
    // state | meaning
    // IDLE  | no AR held; grant an eligible master and capture its AR
    // ISSUE | captured AR presented downstream until m.ARREADY
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);

    state_t                 state, state_nxt;
    logic                   last_grant;
    logic [CW-1:0]          cnt0, cnt1;
    logic                   elig0, elig1, pick, take, ar_done;
    logic                   sel, r_done, inc0, inc1, dec0, dec1;

    logic [ID_WIDTH:0]      arid_q;
    logic [ADDR_WIDTH-1:0]  araddr_q;
    logic [3:0]             arlen_q;
    logic [2:0]             arsize_q;
    logic [1:0]             arburst_q;
    logic [1:0]             arlock_q;
    logic [3:0]             arcache_q;
    logic [2:0]             arprot_q;
    logic [3:0]             arqos_q;

    assign elig0   = s0.ARVALID && (cnt0 < CNT_MAX);
    assign elig1   = s1.ARVALID && (cnt1 < CNT_MAX);
    // On a tie the master that did not win last time goes first.
    assign pick    = (elig0 && elig1) ? ~last_grant : elig1;
    assign take    = ARESETn && (state == IDLE) && (elig0 || elig1);
    assign ar_done = (state == ISSUE) && m.ARREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = ISSUE;
            ISSUE:   if (m.ARREADY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s0.ARREADY = 1'b0;
        s1.ARREADY = 1'b0;
        m.ARVALID  = (state == ISSUE);
        if (take) begin
            s0.ARREADY = ~pick;
            s1.ARREADY = pick;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            arid_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
            arlock_q   <= '0;
            arcache_q  <= '0;
            arprot_q   <= '0;
            arqos_q    <= '0;
            last_grant <= 1'b1;
        end else begin
            if (take) begin
                arid_q    <= pick ? {1'b1, s1.ARID} : {1'b0, s0.ARID};
                araddr_q  <= pick ? s1.ARADDR  : s0.ARADDR;
                arlen_q   <= pick ? s1.ARLEN   : s0.ARLEN;
                arsize_q  <= pick ? s1.ARSIZE  : s0.ARSIZE;
                arburst_q <= pick ? s1.ARBURST : s0.ARBURST;
                arlock_q  <= pick ? s1.ARLOCK  : s0.ARLOCK;
                arcache_q <= pick ? s1.ARCACHE : s0.ARCACHE;
                arprot_q  <= pick ? s1.ARPROT  : s0.ARPROT;
                arqos_q   <= pick ? s1.ARQOS   : s0.ARQOS;
            end
            if (ar_done) begin
                last_grant <= arid_q[ID_WIDTH];
            end
        end
    end

    assign m.ARID    = arid_q;
    assign m.ARADDR  = araddr_q;
    assign m.ARLEN   = arlen_q;
    assign m.ARSIZE  = arsize_q;
    assign m.ARBURST = arburst_q;
    assign m.ARLOCK  = arlock_q;
    assign m.ARCACHE = arcache_q;
    assign m.ARPROT  = arprot_q;
    assign m.ARQOS   = arqos_q;

    assign sel       = m.RID[ID_WIDTH];
    assign s0.RVALID = m.RVALID && !sel;
    assign s0.RDATA  = sel ? '0 : m.RDATA;
    assign s0.RID    = sel ? '0 : m.RID[ID_WIDTH-1:0];
    assign s0.RRESP  = sel ? '0 : m.RRESP;
    assign s0.RLAST  = m.RLAST && !sel;
    assign s1.RVALID = m.RVALID && sel;
    assign s1.RDATA  = sel ? m.RDATA : '0;
    assign s1.RID    = sel ? m.RID[ID_WIDTH-1:0] : '0;
    assign s1.RRESP  = sel ? m.RRESP : '0;
    assign s1.RLAST  = m.RLAST && sel;
    assign m.RREADY  = sel ? s1.RREADY : s0.RREADY;

    assign r_done = m.RVALID && m.RREADY && m.RLAST;
    assign inc0   = ar_done && !arid_q[ID_WIDTH];
    assign inc1   = ar_done && arid_q[ID_WIDTH];
    assign dec0   = r_done && !sel;
    assign dec1   = r_done && sel;

    // A burst issued and another retired in the same cycle cancel out; never wrap below 0.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (inc0 && !dec0) begin
                cnt0 <= cnt0 + CW'(1);
            end else if (dec0 && !inc0 && cnt0 != '0) begin
                cnt0 <= cnt0 - CW'(1);
            end
            if (inc1 && !dec1) begin
                cnt1 <= cnt1 + CW'(1);
            end else if (dec1 && !inc1 && cnt1 != '0) begin
                cnt1 <= cnt1 - CW'(1);
            end
        end
    end

    assign s0.AWREADY = 1'b0;
    assign s0.WREADY  = 1'b0;
    assign s0.BVALID  = 1'b0;
    assign s0.BID     = '0;
    assign s0.BRESP   = '0;
    assign s1.AWREADY = 1'b0;
    assign s1.WREADY  = 1'b0;
    assign s1.BVALID  = 1'b0;
    assign s1.BID     = '0;
    assign s1.BRESP   = '0;

    assign m.AWID    = '0;
    assign m.AWADDR  = '0;
    assign m.AWLEN   = '0;
    assign m.AWSIZE  = '0;
    assign m.AWBURST = '0;
    assign m.AWLOCK  = '0;
    assign m.AWCACHE = '0;
    assign m.AWPROT  = '0;
    assign m.AWQOS   = '0;
    assign m.AWVALID = 1'b0;
    assign m.WID     = '0;
    assign m.WDATA   = '0;
    assign m.WSTRB   = '0;
    assign m.WLAST   = 1'b0;
    assign m.WVALID  = 1'b0;
    assign m.BREADY  = 1'b0;

    logic unused_wr;
    assign unused_wr = ^{s0.AWID, s0.AWADDR, s0.AWLEN, s0.AWSIZE, s0.AWBURST, s0.AWLOCK,
                         s0.AWCACHE, s0.AWPROT, s0.AWQOS, s0.AWVALID, s0.WID, s0.WDATA,
                         s0.WSTRB, s0.WLAST, s0.WVALID, s0.BREADY,
                         s1.AWID, s1.AWADDR, s1.AWLEN, s1.AWSIZE, s1.AWBURST, s1.AWLOCK,
                         s1.AWCACHE, s1.AWPROT, s1.AWQOS, s1.AWVALID, s1.WID, s1.WDATA,
                         s1.WSTRB, s1.WLAST, s1.WVALID, s1.BREADY,
                         m.AWREADY, m.WREADY, m.BID, m.BRESP, m.BVALID,
                         s0.ACLK, s1.ACLK, m.ACLK};

`ifndef SYNTHESIS
    ar_stable: assert property (@(posedge ACLK) disable iff (!ARESETn)
        (m.ARVALID && !m.ARREADY) |=> $stable({m.ARID, m.ARADDR, m.ARLEN, m.ARSIZE, m.ARBURST,
                                               m.ARLOCK, m.ARCACHE, m.ARPROT, m.ARQOS}));
    ar_ready_excl: assert property (@(posedge ACLK) disable iff (!ARESETn)
        !(s0.ARREADY && s1.ARREADY));
    rd_underflow: assert property (@(posedge ACLK) disable iff (!ARESETn)
        !((dec0 && !inc0 && cnt0 == '0) || (dec1 && !inc1 && cnt1 == '0)));
`endif
endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// tb_axi3_rd_arbiter: directed vectors plus hand sequences for the read arbiter.
// dut_a uses MAX_OUTST=8, dut_b uses MAX_OUTST=2 for the outstanding-limit case.
module tb_axi3_rd_arbiter;
    logic aclk;
    logic aresetn;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    axi3_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4)) s0a (.ACLK(aclk));
    axi3_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4)) s1a (.ACLK(aclk));
    axi3_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(5)) ma  (.ACLK(aclk));
    axi3_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4)) s0b (.ACLK(aclk));
    axi3_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4)) s1b (.ACLK(aclk));
    axi3_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(5)) mb  (.ACLK(aclk));

    axi3_rd_arbiter #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4), .MAX_OUTST(8)) dut_a (
        .ACLK(aclk), .ARESETn(aresetn), .s0(s0a), .s1(s1a), .m(ma));
    axi3_rd_arbiter #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4), .MAX_OUTST(2)) dut_b (
        .ACLK(aclk), .ARESETn(aresetn), .s0(s0b), .s1(s1b), .m(mb));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    typedef struct packed {
        logic        s0v;
        logic        s1v;
        logic        mrdy;
        logic        s0r;
        logic        s1r;
        logic        mv;
        logic [11:0] addr;
        logic [4:0]  id;
    } vec_t;

    vec_t vec [12];

    initial begin
        logic odd;
        logic [31:0] data;

        // Upstream-driven signals on all four upstream ports
        s0a.AWID = '0; s0a.AWADDR = '0; s0a.AWLEN = '0; s0a.AWSIZE = '0; s0a.AWBURST = '0;
        s0a.AWLOCK = '0; s0a.AWCACHE = '0; s0a.AWPROT = '0; s0a.AWQOS = '0; s0a.AWVALID = 1'b0;
        s0a.WID = '0; s0a.WDATA = '0; s0a.WSTRB = '0; s0a.WLAST = 1'b0; s0a.WVALID = 1'b0; s0a.BREADY = 1'b0;
        s1a.AWID = '0; s1a.AWADDR = '0; s1a.AWLEN = '0; s1a.AWSIZE = '0; s1a.AWBURST = '0;
        s1a.AWLOCK = '0; s1a.AWCACHE = '0; s1a.AWPROT = '0; s1a.AWQOS = '0; s1a.AWVALID = 1'b0;
        s1a.WID = '0; s1a.WDATA = '0; s1a.WSTRB = '0; s1a.WLAST = 1'b0; s1a.WVALID = 1'b0; s1a.BREADY = 1'b0;
        s0b.AWID = '0; s0b.AWADDR = '0; s0b.AWLEN = '0; s0b.AWSIZE = '0; s0b.AWBURST = '0;
        s0b.AWLOCK = '0; s0b.AWCACHE = '0; s0b.AWPROT = '0; s0b.AWQOS = '0; s0b.AWVALID = 1'b0;
        s0b.WID = '0; s0b.WDATA = '0; s0b.WSTRB = '0; s0b.WLAST = 1'b0; s0b.WVALID = 1'b0; s0b.BREADY = 1'b0;
        s1b.AWID = '0; s1b.AWADDR = '0; s1b.AWLEN = '0; s1b.AWSIZE = '0; s1b.AWBURST = '0;
        s1b.AWLOCK = '0; s1b.AWCACHE = '0; s1b.AWPROT = '0; s1b.AWQOS = '0; s1b.AWVALID = 1'b0;
        s1b.WID = '0; s1b.WDATA = '0; s1b.WSTRB = '0; s1b.WLAST = 1'b0; s1b.WVALID = 1'b0; s1b.BREADY = 1'b0;

        s0a.ARID = 4'h5; s0a.ARADDR = 12'h100; s0a.ARLEN = 4'h3; s0a.ARSIZE = 3'd2; s0a.ARBURST = 2'b01;
        s0a.ARLOCK = '0; s0a.ARCACHE = 4'h2; s0a.ARPROT = '0; s0a.ARQOS = '0; s0a.ARVALID = 1'b1; s0a.RREADY = 1'b0;
        s1a.ARID = 4'hA; s1a.ARADDR = 12'h200; s1a.ARLEN = 4'h7; s1a.ARSIZE = 3'd2; s1a.ARBURST = 2'b10;
        s1a.ARLOCK = '0; s1a.ARCACHE = 4'h3; s1a.ARPROT = 3'd1; s1a.ARQOS = 4'h1; s1a.ARVALID = 1'b0; s1a.RREADY = 1'b0;
        s0b.ARID = '0; s0b.ARADDR = '0; s0b.ARLEN = '0; s0b.ARSIZE = '0; s0b.ARBURST = '0;
        s0b.ARLOCK = '0; s0b.ARCACHE = '0; s0b.ARPROT = '0; s0b.ARQOS = '0; s0b.ARVALID = 1'b0; s0b.RREADY = 1'b0;
        s1b.ARID = 4'h3; s1b.ARADDR = 12'h300; s1b.ARLEN = '0; s1b.ARSIZE = 3'd2; s1b.ARBURST = 2'b01;
        s1b.ARLOCK = '0; s1b.ARCACHE = '0; s1b.ARPROT = '0; s1b.ARQOS = '0; s1b.ARVALID = 1'b0; s1b.RREADY = 1'b0;

        ma.AWREADY = 1'b0; ma.WREADY = 1'b0; ma.BID = '0; ma.BRESP = '0; ma.BVALID = 1'b0;
        ma.ARREADY = 1'b0; ma.RID = '0; ma.RDATA = '0; ma.RRESP = '0; ma.RLAST = 1'b0; ma.RVALID = 1'b0;
        mb.AWREADY = 1'b0; mb.WREADY = 1'b0; mb.BID = '0; mb.BRESP = '0; mb.BVALID = 1'b0;
        mb.ARREADY = 1'b0; mb.RID = '0; mb.RDATA = '0; mb.RRESP = '0; mb.RLAST = 1'b0; mb.RVALID = 1'b0;

        // Round-robin table: {s0v, s1v, m.ARREADY} -> {s0.ARREADY, s1.ARREADY, m.ARVALID, m.ARADDR, m.ARID}
        vec[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 5'h00};
        vec[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h100, 5'h05};
        vec[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h100, 5'h05};
        vec[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h200, 5'h1A};
        vec[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h200, 5'h1A};
        vec[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h100, 5'h05};
        vec[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h100, 5'h05};
        vec[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h200, 5'h1A};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h200, 5'h1A};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h200, 5'h1A};
        vec[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h200, 5'h1A};
        vec[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h200, 5'h1A};

        // Reset held with s0 requesting
        aresetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("rst_m_arvalid", ma.ARVALID, 1'b0);
            chk("rst_s0_arready", s0a.ARREADY, 1'b0);
        end
        chk("rst_m_araddr", ma.ARADDR, 12'h000);
        chk("rst_m_arid", ma.ARID, 5'h00);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        #1;
        chk("first_s0_arready", s0a.ARREADY, 1'b1);
        chk("first_m_arvalid_pre", ma.ARVALID, 1'b0);
        tick();
        chk("first_m_arvalid", ma.ARVALID, 1'b1);
        chk("first_m_arid", ma.ARID, 5'h05);
        chk("first_m_araddr", ma.ARADDR, 12'h100);
        chk("first_s0_arready_off", s0a.ARREADY, 1'b0);

        // Downstream stall: AR must hold while upstream address changes
        s0a.ARADDR = 12'h1FF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_m_arvalid", ma.ARVALID, 1'b1);
            chk("stall_m_araddr", ma.ARADDR, 12'h100);
            chk("stall_m_arlen", ma.ARLEN, 4'h3);
            chk("stall_s0_arready", s0a.ARREADY, 1'b0);
            chk("stall_s1_arready", s1a.ARREADY, 1'b0);
        end
        ma.ARREADY = 1'b1;
        s0a.ARVALID = 1'b0;
        s0a.ARADDR = 12'h100;
        tick();
        chk("stall_done_arvalid", ma.ARVALID, 1'b0);
        chk("stall_done_cnt0", dut_a.cnt0, 4'd1);

        // Reset during ISSUE drops the AR immediately and clears counters
        ma.ARREADY = 1'b0;
        s0a.ARVALID = 1'b1;
        tick();
        chk("mid_pre_arvalid", ma.ARVALID, 1'b1);
        aresetn = 1'b0;
        #1;
        chk("mid_drop_arvalid", ma.ARVALID, 1'b0);
        chk("mid_drop_araddr", ma.ARADDR, 12'h000);
        tick();
        tick();
        chk("mid_cnt0", dut_a.cnt0, 4'd0);
        aresetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            s0a.ARVALID = vec[i].s0v;
            s1a.ARVALID = vec[i].s1v;
            ma.ARREADY  = vec[i].mrdy;
            #1;
            chk($sformatf("rr%0d_s0_arready", i), s0a.ARREADY, vec[i].s0r);
            chk($sformatf("rr%0d_s1_arready", i), s1a.ARREADY, vec[i].s1r);
            chk($sformatf("rr%0d_m_arvalid", i), ma.ARVALID, vec[i].mv);
            chk($sformatf("rr%0d_m_araddr", i), ma.ARADDR, vec[i].addr);
            chk($sformatf("rr%0d_m_arid", i), ma.ARID, vec[i].id);
            tick();
        end
        chk("rr_cnt0", dut_a.cnt0, 4'd2);
        chk("rr_cnt1", dut_a.cnt1, 4'd3);

        // Downstream AR handshake and RLAST for master 0 in the same cycle
        s0a.ARVALID = 1'b1;
        tick();
        tick();
        chk("same_cnt0_pre", dut_a.cnt0, 4'd3);
        tick();
        s0a.ARVALID = 1'b0;
        s0a.RREADY = 1'b1;
        ma.RVALID = 1'b1; ma.RID = 5'h05; ma.RLAST = 1'b1; ma.RDATA = 32'hDEAD_BEEF;
        #1;
        chk("same_m_arvalid", ma.ARVALID, 1'b1);
        chk("same_s0_rvalid", s0a.RVALID, 1'b1);
        chk("same_s0_rid", s0a.RID, 4'h5);
        chk("same_s0_rdata", s0a.RDATA, 32'hDEAD_BEEF);
        chk("same_s1_rvalid", s1a.RVALID, 1'b0);
        chk("same_m_rready", ma.RREADY, 1'b1);
        tick();
        chk("same_cnt0", dut_a.cnt0, 4'd3);
        chk("same_arvalid_off", ma.ARVALID, 1'b0);
        tick();
        ma.RVALID = 1'b0; ma.RLAST = 1'b0;
        chk("dec_cnt0", dut_a.cnt0, 4'd2);

        // Interleaved R beats with s1 not ready
        s0a.RREADY = 1'b1;
        s1a.RREADY = 1'b0;
        ma.RVALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            odd  = (k % 2) == 1;
            data = 32'hA5A5_0000 + k;
            ma.RID   = odd ? 5'h12 : 5'h02;
            ma.RDATA = data;
            ma.RLAST = odd;
            #1;
            chk($sformatf("il%0d_m_rready", k), ma.RREADY, !odd);
            chk($sformatf("il%0d_s0_rvalid", k), s0a.RVALID, !odd);
            chk($sformatf("il%0d_s1_rvalid", k), s1a.RVALID, odd);
            chk($sformatf("il%0d_s0_rdata", k), s0a.RDATA, odd ? 32'h0 : data);
            chk($sformatf("il%0d_s1_rdata", k), s1a.RDATA, odd ? data : 32'h0);
            chk($sformatf("il%0d_s0_rid", k), s0a.RID, odd ? 4'h0 : 4'h2);
            chk($sformatf("il%0d_s1_rid", k), s1a.RID, odd ? 4'h2 : 4'h0);
            tick();
        end
        ma.RVALID = 1'b0; ma.RLAST = 1'b0;
        #1;
        chk("il_cnt0", dut_a.cnt0, 4'd2);
        chk("il_cnt1", dut_a.cnt1, 4'd3);

        // Outstanding limit of 2 on dut_b
        s1b.ARVALID = 1'b1;
        mb.ARREADY = 1'b1;
        #1;
        chk("lim_rdy0", s1b.ARREADY, 1'b1);
        tick();
        tick();
        chk("lim_rdy1", s1b.ARREADY, 1'b1);
        tick();
        tick();
        chk("lim_cnt1_full", dut_b.cnt1, 2'd2);
        chk("lim_stall_rdy", s1b.ARREADY, 1'b0);
        tick();
        chk("lim_stall_rdy2", s1b.ARREADY, 1'b0);
        chk("lim_stall_arvalid", mb.ARVALID, 1'b0);
        s1b.RREADY = 1'b1;
        mb.RVALID = 1'b1; mb.RID = 5'h13; mb.RLAST = 1'b1; mb.RDATA = 32'h1234_5678;
        #1;
        chk("lim_s1_rid", s1b.RID, 4'h3);
        chk("lim_s1_rvalid", s1b.RVALID, 1'b1);
        chk("lim_s0_rvalid", s0b.RVALID, 1'b0);
        chk("lim_m_rready", mb.RREADY, 1'b1);
        tick();
        mb.RVALID = 1'b0; mb.RLAST = 1'b0;
        #1;
        chk("lim_cnt1_dec", dut_b.cnt1, 2'd1);
        chk("lim_regrant_rdy", s1b.ARREADY, 1'b1);
        tick();
        chk("lim_regrant_arvalid", mb.ARVALID, 1'b1);
        chk("lim_regrant_arid", mb.ARID, 5'h13);
        chk("lim_regrant_araddr", mb.ARADDR, 12'h300);
        s1b.ARVALID = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
